// File: rtl/bist_sig_checker.sv
// bist_sig_checker: end-of-session checker for the TRNG BIST MISR signature.
// It counts MISR steps, captures the signature once the programmed count is
// reached, compares it against the golden value, then unloads the captured
// word serially (LSB first) over a valid/ready link.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet
// S_COUNT  | counting misr_step pulses up to N_STEPS
// S_CAPTURE| one cycle: latch signature, register pass/fail
// S_UNLOAD | shifting captured signature out, one bit per accepted xfer
// S_DONE   | session complete; pass/fail held until the next start
module bist_sig_checker #(
  parameter int                SIG_W   = 32,
  parameter int                CNT_W   = 22,
  parameter logic [CNT_W-1:0]  N_STEPS = 22'd2184500,
  parameter logic [SIG_W-1:0]  GOLDEN  = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             misr_step,
  input  logic [SIG_W-1:0] signature,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             sout,
  output logic             sout_valid,
  output logic [CNT_W-1:0] step_count
);

  localparam int               BIT_W    = $clog2(SIG_W);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(SIG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SIG_W-1:0] cap_q;
  logic [BIT_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] step_count_q;
  logic [CNT_W-1:0] step_inc;
  logic             pass_q;
  logic             fail_q;

  // Control strobes from the FSM to the datapath registers.
  logic clr_session;
  logic inc_step;
  logic do_capture;
  logic xfer;

  assign step_inc = step_count_q + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, datapath strobes and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    clr_session = 1'b0;
    inc_step    = 1'b0;
    do_capture  = 1'b0;
    xfer        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sout_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A step coinciding with start belongs to no session and is dropped.
        if (start) begin
          clr_session = 1'b1;
          state_d     = S_COUNT;
        end
      end
      S_COUNT: begin
        busy = 1'b1;
        if (misr_step) begin
          inc_step = 1'b1;
          if (step_inc == N_STEPS) begin
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        busy       = 1'b1;
        do_capture = 1'b1;
        state_d    = S_UNLOAD;
      end
      S_UNLOAD: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        if (sout_ready) begin
          xfer = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clr_session = 1'b1;
          state_d     = S_COUNT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Step counter: cleared at session start, bumped on each counted step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_count_q <= '0;
    end else if (clr_session) begin
      step_count_q <= '0;
    end else if (inc_step) begin
      step_count_q <= step_inc;
    end
  end

  // Capture register: the MISR value is valid in the cycle after its last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q <= '0;
    end else if (do_capture) begin
      cap_q <= signature;
    end
  end

  // Verdict flags: registered at capture, dropped when a new session starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (clr_session) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if (do_capture) begin
      pass_q <= (signature == GOLDEN);
      fail_q <= (signature != GOLDEN);
    end
  end

  // Serial bit index: reset to bit 0 on capture, advanced per accepted transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx_q <= '0;
    end else if (clr_session || do_capture) begin
      bit_idx_q <= '0;
    end else if (xfer) begin
      bit_idx_q <= bit_idx_q + BIT_W'(1);
    end
  end

  // Gate the data bit with valid so sout is quiet outside UNLOAD.
  assign sout       = sout_valid & cap_q[bit_idx_q];
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed self-checking bench for bist_sig_checker with an 8-step session.
module tb_bist_sig_checker;

  localparam logic [21:0] N_STEPS = 22'd8;
  localparam logic [31:0] GOLD    = 32'hA5A5_0F0F;
  localparam logic [31:0] BAD     = 32'hA5A5_0F0E;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        misr_step = 1'b0;
  logic [31:0] signature = 32'h0;
  logic        sout_ready = 1'b0;
  logic        busy, done, pass, fail, sout, sout_valid;
  logic [21:0] step_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bist_sig_checker #(
    .SIG_W  (32),
    .CNT_W  (22),
    .N_STEPS(N_STEPS),
    .GOLDEN (GOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .misr_step (misr_step),
    .signature (signature),
    .sout_ready(sout_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .sout      (sout),
    .sout_valid(sout_valid),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) begin
      misr_step = 1'b1;
      tick();
    end
    misr_step = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_sout"}, sout, 0);
    chk({tag, "_valid"}, sout_valid, 0);
    chk({tag, "_cnt"}, step_count, 0);
  endtask

  // Drives sout_ready from a repeating 4-cycle pattern and collects the bits.
  task automatic unload(input logic [3:0] pat, output logic [31:0] word, output int nxfer);
    int   cyc = 0;
    logic prev_bit = 1'b0;
    logic prev_stall = 1'b0;
    word  = 32'h0;
    nxfer = 0;
    while (sout_valid && cyc < 400) begin
      sout_ready = pat[cyc % 4];
      if (prev_stall) chk("stall_stable", sout, prev_bit);
      if (sout_ready && nxfer < 32) begin
        word[nxfer] = sout;
        nxfer++;
      end
      prev_bit   = sout;
      prev_stall = !sout_ready;
      tick();
      cyc++;
    end
    sout_ready = 1'b0;
    chk("unload_in_budget", (cyc < 400), 1);
  endtask

  initial begin
    logic [31:0] word;
    int          nx;

    // Test 1: reset, then idle with no start.
    tick();
    chk_quiet("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk_quiet("idle100");

    // Test 2: matching signature.
    signature = GOLD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_cnt0", step_count, 0);
    steps(7);
    chk("t2_cnt7", step_count, 7);
    chk("t2_pass_early", pass, 0);
    misr_step = 1'b1;                // 8th step
    tick();
    chk("t2_cnt8", step_count, 8);
    chk("t2_cap_pass", pass, 0);
    chk("t2_cap_valid", sout_valid, 0);
    tick();                          // capture cycle; step here is ignored
    misr_step = 1'b0;
    chk("t2_cnt_hold", step_count, 8);
    chk("t2_pass", pass, 1);
    chk("t2_fail", fail, 0);
    chk("t2_valid", sout_valid, 1);
    chk("t2_bit0", sout, 1);
    unload(4'b1111, word, nx);
    chk("t2_word", word, GOLD);
    chk("t2_nxfer", nx, 32);
    chk("t2_done", done, 1);
    chk("t2_busy_done", busy, 0);
    chk("t2_pass_held", pass, 1);
    steps(3);
    chk("t2_cnt_no_wrap", step_count, 8);

    // Tests 3+4: mismatching signature, stalling consumer.
    signature = BAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done_clr", done, 0);
    chk("t3_pass_clr", pass, 0);
    steps(8);
    tick();
    chk("t3_fail", fail, 1);
    chk("t3_pass", pass, 0);
    chk("t3_bit0", sout, 0);
    unload(4'b1001, word, nx);
    chk("t4_word", word, BAD);
    chk("t4_nxfer", nx, 32);
    chk("t4_done", done, 1);
    chk("t4_fail_held", fail, 1);

    // Test 5: async reset mid-session, then restart with a redundant start.
    start = 1'b1;
    tick();
    start = 1'b0;
    steps(4);
    chk("t5_cnt4", step_count, 4);
    misr_step = 1'b1;
    rst = 1'b0;
    #1;
    chk_quiet("t5_rst");
    misr_step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_quiet("t5_after");
    signature = GOLD;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_cnt0", step_count, 0);
    steps(3);
    start = 1'b1;
    misr_step = 1'b1;
    tick();
    start = 1'b0;
    misr_step = 1'b0;
    chk("t5_start_ignored", step_count, 4);
    chk("t5_busy", busy, 1);
    steps(4);
    tick();
    chk("t5_pass", pass, 1);
    unload(4'b1111, word, nx);
    chk("t5_word", word, GOLD);
    chk("t5_done", done, 1);

    // Test 6: start and misr_step together in DONE.
    signature = BAD;
    start = 1'b1;
    misr_step = 1'b1;
    tick();
    start = 1'b0;
    misr_step = 1'b0;
    chk("t6_cnt0", step_count, 0);
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 1);
    chk("t6_pass", pass, 0);
    steps(8);
    tick();
    chk("t6_fail", fail, 1);
    unload(4'b0110, word, nx);
    chk("t6_word", word, BAD);
    chk("t6_nxfer", nx, 32);
    chk("t6_done_end", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
